bitstuff_tx: RTL
================

// Module: bitstuff_tx
// PURPOSE
//  Serial bit-stuffing transmitter that feeds the single-bit "in" line of the
//  run-detector FSMs. It accepts parallel words over a valid/ready handshake
//  and shifts each word out MSB-first, one bit per clock. After RUN_MAX
//  identical consecutive bits it inserts one complement "stuff" bit, so the
//  line never carries a run longer than RUN_MAX. Downstream detectors can then
//  treat any longer run as a framing or error event.
// PARAMETERS
//  DATA_W   8  width of a parallel input word (>=1)
//  RUN_MAX  3  max identical consecutive bits before a stuff bit (>=1)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  in_valid   in   1       in_data holds a word to send
//  in_ready   out  1       block can accept a word this cycle
//  in_data    in   DATA_W  parallel word, sampled only at accept
//  out        out  1       serial bit (registered)
//  out_valid  out  1       out carries a data or stuff bit this cycle
//  stuffed    out  1       current out bit is a stuff bit
//  busy       out  1       word in flight (state != IDLE)
// BEHAVIOUR
//  - Reset (async): state=IDLE; out=0, out_valid=0, stuffed=0, busy=0;
//    shift reg, bit counter and run state cleared. Reset mid-word drops the
//    word; no partial completion after release.
//  - in_ready = (state==IDLE), combinational. Accept = in_valid & in_ready
//    at a rising edge. in_valid while not ready is ignored; no queueing.
//  - States:
//    - IDLE: on accept, load in_data, bitcnt=DATA_W, clear run, go to SHIFT.
//    - SHIFT: register out=MSB, out_valid=1, stuffed=0; shift left; bitcnt-1.
//      Update run: same as last_bit -> run+1, else run=1, last_bit=bit.
//      If run reaches RUN_MAX, go to STUFF.
//      Else if bitcnt reaches 0, go to IDLE.
//      Else stay in SHIFT.
//    - STUFF: register out=~last_bit, out_valid=1, stuffed=1. The stuff bit
//      starts a new run: last_bit=~last_bit, run=1. If bitcnt==0 go to IDLE,
//      else go to SHIFT.
//  - A stuff bit is emitted even after the final data bit when the run hits
//    RUN_MAX, so the receiver rule is fully deterministic.
//  - Latency: accept at edge k -> first bit (MSB) visible after edge k+1.
//    One bit per cycle, no bubbles inside a word. Word length is DATA_W plus
//    the number of stuff bits.
//  - Run state never spans words. It clears in IDLE, and a minimum of one
//    idle cycle separates consecutive words.
//  - Idle line: out=0, out_valid=0, stuffed=0.
//  - RUN_MAX=1: every data bit is followed by its complement.
//  - Counters are sized $clog2(DATA_W+1) and $clog2(RUN_MAX+1); no wrap.
// TESTING
//  1 DATA_W=8, RUN_MAX=3, send 8'hA5 -> out 1,0,1,0,0,1,0,1 over 8 cycles;
//    stuffed never set; in_ready back high the cycle after the last bit.
//  2 Send 8'hFF -> 1,1,1,0s,1,1,1,0s,1,1 (10 bits, s=stuffed high at bits 4
//    and 8); out_valid high for exactly 10 cycles.
//  3 Send 8'hE0 -> 1,1,1,0s,0,0,1s,0,0,0,1s (11 bits). Checks that a stuff bit
//    starts a new run and that a stuff bit is emitted after the final data bit.
//  4 Send 8'h00 then 8'hFF back-to-back (in_valid held high) -> second word
//    accepted only in IDLE; one idle cycle between words; run does not carry
//    over.
//  5 Assert reset for 1 cycle during bit 4 of 8'hFF -> out/out_valid/stuffed
//    drop to 0 immediately (async); in_ready=1 after release; next word 8'h0F
//    sent cleanly as 0,0,0,1s,0,1,1,1,0s,1.
//  6 RUN_MAX=1, DATA_W=4, send 4'b1100 -> 1,0s,1,0s,0,1s,0,1s (8 bits).

Source files
------------

// File: rtl/bitstuff_tx.sv
// Bit-stuffing serial transmitter: takes parallel words over valid/ready, shifts
// them out MSB-first and inserts a complement bit after every RUN_MAX-long run.
module bitstuff_tx #(
  parameter int DATA_W  = 8,
  parameter int RUN_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out,
  output logic              out_valid,
  output logic              stuffed,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int RUN_W = $clog2(RUN_MAX + 1);
  localparam logic [CNT_W-1:0] DATA_W_C  = CNT_W'(DATA_W);
  localparam logic [RUN_W-1:0] RUN_MAX_C = RUN_W'(RUN_MAX);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STUFF = 2'd2
  } state_t;

  // Handshake: a word is taken on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and in_data is looked at only on that edge.
  state_t            r_state, w_state;
  logic [DATA_W-1:0] r_sh, w_sh;
  logic [CNT_W-1:0]  r_bitcnt, w_bitcnt;
  logic [RUN_W-1:0]  r_run, w_run;
  logic              r_last, w_last;
  logic              r_out, w_out;
  logic              r_out_valid, w_out_valid;
  logic              r_stuffed, w_stuffed;
  logic              w_bit;

  assign w_bit     = r_sh[DATA_W-1];
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign stuffed   = r_stuffed;

  always_comb begin
    w_state     = r_state;
    w_sh        = r_sh;
    w_bitcnt    = r_bitcnt;
    w_run       = r_run;
    w_last      = r_last;
    w_out       = 1'b0;
    w_out_valid = 1'b0;
    w_stuffed   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_run  = '0;
        w_last = 1'b0;
        if (in_valid) begin
          w_sh     = in_data;
          w_bitcnt = DATA_W_C;
          w_state  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_out       = w_bit;
        w_out_valid = 1'b1;
        w_sh        = r_sh << 1;
        w_bitcnt    = r_bitcnt - 1'b1;
        // run==0 means no bit seen yet in this word. The count saturates so a
        // data bit matching the preceding stuff bit with RUN_MAX=1 cannot wrap.
        if ((r_run != '0) && (w_bit == r_last)) begin
          w_run = (r_run == RUN_MAX_C) ? r_run : r_run + RUN_ONE;
        end else begin
          w_run  = RUN_ONE;
          w_last = w_bit;
        end
        if (w_run == RUN_MAX_C) begin
          w_state = S_STUFF;
        end else if (w_bitcnt == '0) begin
          w_state = S_IDLE;
        end
      end
      S_STUFF: begin
        w_out       = ~r_last;
        w_out_valid = 1'b1;
        w_stuffed   = 1'b1;
        w_last      = ~r_last;
        w_run       = RUN_ONE;
        w_state     = (r_bitcnt == '0) ? S_IDLE : S_SHIFT;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_bitcnt    <= '0;
      r_run       <= '0;
      r_last      <= 1'b0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_stuffed   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sh        <= w_sh;
      r_bitcnt    <= w_bitcnt;
      r_run       <= w_run;
      r_last      <= w_last;
      r_out       <= w_out;
      r_out_valid <= w_out_valid;
      r_stuffed   <= w_stuffed;
    end
  end

endmodule
